dma_stream_framer: RTL and testbench

Downstream stage of the DSP accelerator's output DMA. Accepts the DMA's free-running sample stream (valid only, no backpressure), buffers it in a first-word-fall-through FIFO, and re-emits it on a ready/valid link toward the chiplet interface. Each sample carries a `m_last` flag marking the final sample of every `BLOCK_SIZE` block. The block also flags overflow and short-block errors.

---
 rtl/dma_stream_framer.sv | 141 ++++++++++++++
 tb/tb_dma_stream_framer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_stream_framer.sv
// rtl/dma_stream_framer.sv - block framer and FWFT buffer between the output DMA and the chiplet link
//
// Buffers the DMA's free-running sample stream (no backpressure) in a
// first-word-fall-through FIFO and re-emits it on a ready/valid link.
// Each sample is tagged with m_last when it closes a BLOCK_SIZE block.
// Dropped samples raise the sticky overflow flag; an in_done pulse that
// arrives mid-block raises the sticky short_block flag and resyncs framing.
//
// Optional feature: define DMA_FRAMER_PARITY_EN to add m_parity (XOR of the
// sample bits, captured at write time and presented with the head entry).
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_data, in_valid       DMA sample stream (cannot be stalled)
//   in_done                 one-cycle end-of-block pulse from the DMA
//   m_data, m_last, m_valid FIFO head, block-end tag, non-empty
//   m_ready                 consumer accepts head on m_valid && m_ready
//   clr_flags               clears overflow and short_block
//   overflow, short_block   sticky error flags
//   fifo_level              current FIFO occupancy
//   m_parity                head parity (DMA_FRAMER_PARITY_EN only)

module dma_stream_framer #(
    parameter int DATA_WIDTH = 12,
    parameter int BLOCK_SIZE = 256,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic                          in_done,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    input  logic                          clr_flags,
    output logic                          overflow,
    output logic                          short_block,
`ifdef DMA_FRAMER_PARITY_EN
    output logic                          m_parity,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BLOCK_SIZE);
`ifdef DMA_FRAMER_PARITY_EN
    localparam int EW = DATA_WIDTH + 2;
`else
    localparam int EW = DATA_WIDTH + 1;
`endif
    localparam logic [CW-1:0] CNT_MAX  = CW'(BLOCK_SIZE - 1);
    localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);

    // Entry layout: {[parity,] data, last}
    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   head;
    logic            full;
    logic            rd_en;
    logic            wr_en;
    logic            is_last;
    logic            ovf_set;
    logic            short_set;

    assign m_valid = (level != '0);
    assign full    = (level == LVL_FULL);
    assign rd_en   = m_valid && m_ready;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en   = in_valid && (!full || rd_en);
    assign is_last = (cnt == CNT_MAX);

    // Counter advances on every in_valid, dropped or not, so framing survives overflow.
    always_comb begin
        cnt_inc = cnt;
        if (in_valid) begin
            cnt_inc = is_last ? '0 : cnt + CW'(1);
        end
    end

    // in_done is judged against the post-increment count: a pulse on the
    // closing sample of a block is a clean end, anything else is short.
    assign ovf_set   = in_valid && !wr_en;
    assign short_set = in_done && (cnt_inc != '0);

`ifdef DMA_FRAMER_PARITY_EN
    assign wr_entry = {^in_data, in_data, is_last};
`else
    assign wr_entry = {in_data, is_last};
`endif

    // Storage is not reset; the head is masked to zero while empty instead.
    assign head   = m_valid ? mem[rd_ptr] : '0;
    assign m_last = head[0];
    assign m_data = head[DATA_WIDTH:1];
`ifdef DMA_FRAMER_PARITY_EN
    assign m_parity = head[EW-1];
`endif

    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            cnt         <= '0;
            overflow    <= 1'b0;
            short_block <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
            cnt         <= short_set ? '0 : cnt_inc;
            // Set beats clear when both happen in the same cycle.
            overflow    <= ovf_set   | (overflow    & ~clr_flags);
            short_block <= short_set | (short_block & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_dma_stream_framer.sv
// tb/tb_dma_stream_framer.sv - self-checking bench for dma_stream_framer

module tb_dma_stream_framer;

    localparam int DW = 12;
    localparam int BS = 8;
    localparam int FD = 4;

    logic          clk;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_done;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic          clr_flags;
    logic          overflow;
    logic          short_block;
    logic [2:0]    fifo_level;
`ifdef DMA_FRAMER_PARITY_EN
    logic          m_parity;
`endif

    dma_stream_framer #(
        .DATA_WIDTH(DW),
        .BLOCK_SIZE(BS),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_done    (in_done),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .clr_flags  (clr_flags),
        .overflow   (overflow),
        .short_block(short_block),
`ifdef DMA_FRAMER_PARITY_EN
        .m_parity   (m_parity),
`endif
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Reference model: a queue of {data,last}, the position inside the block,
    // and the two sticky flags.
    typedef struct {
        int data;
        bit last;
    } ent_t;

    ent_t mq[$];
    int   mpos;
    bit   mo;
    bit   ms;

    task automatic model_reset();
        mq.delete();
        mpos = 0;
        mo   = 0;
        ms   = 0;
    endtask

    task automatic model_step();
        bit   rd;
        bit   acc;
        bit   oset;
        bit   sset;
        ent_t e;
        rd   = (mq.size() > 0) && m_ready;
        acc  = in_valid && ((mq.size() < FD) || rd);
        oset = in_valid && !acc;
        if (in_valid) begin
            mpos   = (mpos + 1) % BS;
            e.data = int'(in_data);
            e.last = (mpos == 0);
        end
        if (rd) void'(mq.pop_front());
        if (acc) mq.push_back(e);
        sset = in_done && (mpos != 0);
        if (sset) mpos = 0;
        mo = oset | (mo & !clr_flags);
        ms = sset | (ms & !clr_flags);
    endtask

    task automatic model_check(input string tag);
        bit v;
        v = (mq.size() > 0);
        chk({tag, " m_valid"},     m_valid,     int'(v));
        chk({tag, " m_data"},      m_data,      v ? mq[0].data : 0);
        chk({tag, " m_last"},      m_last,      v ? int'(mq[0].last) : 0);
        chk({tag, " fifo_level"},  fifo_level,  mq.size());
        chk({tag, " overflow"},    overflow,    int'(mo));
        chk({tag, " short_block"}, short_block, int'(ms));
`ifdef DMA_FRAMER_PARITY_EN
        begin
            logic [DW-1:0] hd;
            hd = v ? DW'(mq[0].data) : '0;
            chk({tag, " m_parity"}, m_parity, int'(^hd));
        end
`endif
    endtask

    task automatic apply(input bit iv, input int d, input bit dn, input bit rdy, input bit clr);
        in_valid  = iv;
        in_data   = DW'(d);
        in_done   = dn;
        m_ready   = rdy;
        clr_flags = clr;
        @(posedge clk);
        #1;
        model_step();
    endtask

    typedef struct {
        bit iv; int d; bit dn; bit rdy; bit clr;
        bit ev; int ed; bit el; int elv; bit eo; bit es;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit iv, int d, bit dn, bit rdy, bit clr,
                                bit ev, int ed, bit el, int elv, bit eo, bit es);
        vec_t v;
        v.iv = iv; v.d = d; v.dn = dn; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.el = el; v.elv = elv; v.eo = eo; v.es = es;
        tbl.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int thr;
        // Full block streaming
        for (int k = 1; k <= 8; k++) add(1, k, 0, 1, 0, 1, k, (k == 8), 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Backpressure overflow, then framing continuity
        for (int k = 0; k < 6; k++) add(1, 10 + k, 0, 0, 0, 1, 10, 0, (k < 4) ? k + 1 : 4, (k >= 4), 0);
        add(0, 0, 0, 1, 0, 1, 11, 0, 3, 1, 0);
        add(0, 0, 0, 1, 0, 1, 12, 0, 2, 1, 0);
        add(0, 0, 0, 1, 0, 1, 13, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add(1, 16, 0, 1, 0, 1, 16, 0, 1, 0, 0);
        add(1, 17, 0, 1, 0, 1, 17, 1, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Full plus read
        for (int k = 0; k < 4; k++) add(1, 30 + k, 0, 0, 0, 1, 30, 0, k + 1, 0, 0);
        add(1, 34, 0, 1, 0, 1, 31, 0, 4, 0, 0);
        add(0, 0, 0, 1, 0, 1, 32, 0, 3, 0, 0);
        add(0, 0, 0, 1, 0, 1, 33, 0, 2, 0, 0);
        add(0, 0, 0, 1, 0, 1, 34, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Short block: 5 samples (30..34) then in_done
        add(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) add(1, 40 + k, 0, 1, 0, 1, 40 + k, (k == 7), 1, 0, 1);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        // in_done on the closing sample
        for (int k = 0; k < 8; k++) add(1, 50 + k, (k == 7), 1, 0, 1, 50 + k, (k == 7), 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Set wins over clear
        add(1, 60, 0, 1, 0, 1, 60, 0, 1, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

        reset_n = 1'b0; in_valid = 0; in_data = '0; in_done = 0; m_ready = 0; clr_flags = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data", m_data, 0);
        chk("reset m_last", m_last, 0);
        chk("reset fifo_level", fifo_level, 0);
        chk("reset overflow", overflow, 0);
        chk("reset short_block", short_block, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            apply(tbl[i].iv, tbl[i].d, tbl[i].dn, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("row%0d m_valid", i), m_valid, int'(tbl[i].ev));
            chk($sformatf("row%0d m_data", i), m_data, tbl[i].ed);
            chk($sformatf("row%0d m_last", i), m_last, int'(tbl[i].el));
            chk($sformatf("row%0d fifo_level", i), fifo_level, tbl[i].elv);
            chk($sformatf("row%0d overflow", i), overflow, int'(tbl[i].eo));
            chk($sformatf("row%0d short_block", i), short_block, int'(tbl[i].es));
        end

        // Reset mid-block with buffered data and a raised flag
        apply(1, 70, 1, 0, 0); model_check("pre-reset 70");
        apply(1, 71, 0, 0, 0); model_check("pre-reset 71");
        apply(1, 72, 0, 0, 0); model_check("pre-reset 72");
        apply(0, 0, 0, 0, 0);
        chk("pre-reset level", fifo_level, 3);
        chk("pre-reset short", short_block, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset m_valid", m_valid, 0);
        chk("async reset fifo_level", fifo_level, 0);
        chk("async reset m_data", m_data, 0);
        chk("async reset short_block", short_block, 0);
        chk("async reset overflow", overflow, 0);
        #1 reset_n = 1'b1;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            apply(1, 80 + k, 0, 1, 0);
            chk($sformatf("post-reset m_last %0d", k), m_last, int'(k == 7));
            model_check($sformatf("post-reset %0d", k));
        end
        apply(0, 0, 0, 1, 0);
        model_check("post-reset drain");

        // Randomized traffic against the reference model
        thr = 60;
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) begin
                case ($urandom_range(0, 2))
                    0:       thr = 20;
                    1:       thr = 60;
                    default: thr = 95;
                endcase
            end
            apply($urandom_range(0, 99) < 75, int'($urandom_range(0, 4095)),
                  $urandom_range(0, 99) < 4, $urandom_range(0, 99) < thr,
                  $urandom_range(0, 99) < 5);
            model_check($sformatf("rand%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
